// File: rtl/ram_pkg.sv
// ram_pkg
// Shared defaults and access decode for single_port_sync_ram.
//   DEF_ADDR_WIDTH / DEF_DATA_WIDTH / DEF_DEPTH : default geometry
//   access_e                                    : idle / write / read / illegal
//   decode_access(cs, we, oe)                   : control pins -> access_e
package ram_pkg;

    localparam int DEF_ADDR_WIDTH = 4;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_DEPTH      = 16;

    typedef enum logic [1:0] {
        ACC_IDLE    = 2'd0,
        ACC_WRITE   = 2'd1,
        ACC_READ    = 2'd2,
        ACC_ILLEGAL = 2'd3
    } access_e;

    // we=1 with oe=1 means both sides would drive the bus, so it is treated
    // as a no-op. cs=1 with we=0/oe=0 is simply idle.
    function automatic access_e decode_access(input logic cs, input logic we, input logic oe);
        access_e acc;
        acc = ACC_IDLE;
        if (cs) begin
            case ({we, oe})
                2'b10:   acc = ACC_WRITE;
                2'b01:   acc = ACC_READ;
                2'b11:   acc = ACC_ILLEGAL;
                default: acc = ACC_IDLE;
            endcase
        end
        return acc;
    endfunction

endpackage

// File: rtl/single_port_sync_ram_bus_tristate_driver.sv
// bus_tristate_driver
// The only place the RAM drives the shared bus, so a pad/IO-cell version can
// be swapped in without touching the array logic.
//   i_en   : 1 = drive i_data onto io_bus, 0 = release (Z)
//   i_data : word to drive
//   io_bus : shared bidirectional bus
module bus_tristate_driver #(
    parameter int WIDTH = 32
) (
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_data,
    inout  wire  [WIDTH-1:0] io_bus
);

    assign io_bus = i_en ? i_data : {WIDTH{1'bz}};

endmodule

// File: rtl/single_port_sync_ram.sv
// single_port_sync_ram
// Single-port synchronous RAM on a shared bidirectional data bus.
//   clk           : rising-edge clock
//   reset         : synchronous active-high; clears array and read register
//   address       : word address (address >= DEPTH is out of range)
//   data_bus      : write data in / read data out, Z when not reading
//   chip_select   : active-high access enable
//   write_enable  : 1 = write cycle, 0 = read cycle
//   output_enable : permits the RAM to drive data_bus on reads
// Reads are registered: the word captured at the end of read cycle n is on
// the bus during cycle n+1 while read controls stay asserted.
module single_port_sync_ram
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    inout  wire  [DATA_WIDTH-1:0] data_bus,
    input  logic                  chip_select,
    input  logic                  write_enable,
    input  logic                  output_enable
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_q;

    access_e          w_acc;
    logic             w_in_range;
    logic [IDX_W-1:0] w_idx;
    logic             w_drive;

    assign w_acc      = decode_access(chip_select, write_enable, output_enable);
    assign w_in_range = (32'(address) < 32'(DEPTH));
    // Only used when w_in_range, so the truncated index is always valid.
    assign w_idx      = IDX_W'(address);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_q <= '0;
        end else begin
            if (w_acc == ACC_WRITE && w_in_range) begin
                r_mem[w_idx] <= data_bus;
            end
            // Out-of-range reads return 0 rather than holding the old word.
            if (w_acc == ACC_READ) begin
                r_rd_q <= w_in_range ? r_mem[w_idx] : '0;
            end
        end
    end

    // Combinational release: any control change drops the bus immediately.
    assign w_drive = !reset && (w_acc == ACC_READ);

    bus_tristate_driver #(
        .WIDTH (DATA_WIDTH)
    ) u_bus_drv (
        .i_en   (w_drive),
        .i_data (r_rd_q),
        .io_bus (data_bus)
    );

endmodule

// File: tb/tb_single_port_sync_ram.sv
module tb_single_port_sync_ram;

    localparam int AW    = 5;   // wider than needed so out-of-range addresses exist
    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam logic [DW-1:0] FLOAT = {DW{1'b1}};  // bus value when nobody drives

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] address = '0;
    logic          chip_select = 1'b0;
    logic          write_enable = 1'b0;
    logic          output_enable = 1'b0;
    logic          tb_en = 1'b0;
    logic [DW-1:0] tb_drv = '0;
    wire  [DW-1:0] data_bus;

    assign data_bus = tb_en ? tb_drv : {DW{1'bz}};
    pullup (data_bus);

    always #5 clk = ~clk;

    single_port_sync_ram #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .address       (address),
        .data_bus      (data_bus),
        .chip_select   (chip_select),
        .write_enable  (write_enable),
        .output_enable (output_enable)
    );

    // Reference model: memory contents and the word the bus should show
    // on the next read cycle.
    logic [DW-1:0] m_mem [DEPTH];
    logic [DW-1:0] m_last;
    logic [DW-1:0] exp_q [$];
    int n_checks = 0;
    int n_errors = 0;
    bit started = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // One bus cycle: apply controls, queue the expected read data, then
    // advance the model at the closing edge.
    task automatic cyc(input logic rs, input logic cs, input logic we, input logic oe,
                       input logic [AW-1:0] a, input logic [DW-1:0] d, input logic drv);
        bit rd, wr;
        reset = rs; chip_select = cs; write_enable = we; output_enable = oe;
        address = a; tb_drv = d; tb_en = drv;
        started = 1;
        rd = !rs && cs && !we && oe;
        wr = !rs && cs && we && !oe;
        if (rd) exp_q.push_back(m_last);
        @(posedge clk);
        if (rs) begin
            foreach (m_mem[i]) m_mem[i] = '0;
            m_last = '0;
        end else if (rd) begin
            m_last = (int'(a) < DEPTH) ? m_mem[int'(a)] : '0;
        end else if (wr && int'(a) < DEPTH) begin
            m_mem[int'(a)] = drv ? d : FLOAT;
        end
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        cyc(0, 1, 1, 0, a, d, 1);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        cyc(0, 1, 0, 1, a, '0, 0);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, '0, '0, 0);
    endtask

    // Read 0..DEPTH-1 back-to-back, plus one trailing read so the last
    // word is seen on the bus.
    task automatic read_all();
        for (int i = 0; i < DEPTH; i++) rd(AW'(i));
        rd(AW'(0));
        idle();
    endtask

    // Monitor: whenever the RAM should be presenting data, compare against
    // the queue; otherwise, if the bench is not driving, the bus must float.
    always @(negedge clk) begin
        if (started) begin
            if (!reset && chip_select && !write_enable && output_enable) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL read_unexpected @%0t: got %h expected no read", $time, data_bus);
                end else begin
                    check("read_data", data_bus, exp_q.pop_front());
                end
            end else if (tb_en) begin
                check("no_contention", data_bus, tb_drv);
            end else begin
                check("bus_z", data_bus, FLOAT);
            end
        end
    end

    initial begin
        logic [DW-1:0] words [DEPTH];
        logic [DW-1:0] d;
        logic          rs, cs, we, oe, drv;

        foreach (m_mem[i]) m_mem[i] = '0;
        m_last = '0;

        // Reset with read controls asserted: bus must float.
        cyc(1, 1, 0, 1, AW'(2), '0, 0);
        cyc(1, 1, 0, 1, AW'(3), '0, 0);
        idle();
        read_all();

        // Sixteen distinct words, read back back-to-back.
        words[0] = 32'h12153524;
        words[1] = 32'hC0895E81;
        for (int i = 2; i < DEPTH; i++) words[i] = $urandom() ^ (i << 8);
        for (int i = 0; i < DEPTH; i++) wr(AW'(i), words[i]);
        read_all();

        // Read-after-write, same address, consecutive cycles.
        wr(AW'(5), 32'hDEADBEEF);
        rd(AW'(5));
        rd(AW'(5));
        wr(AW'(5), 32'h00000000);
        rd(AW'(5));
        rd(AW'(5));
        idle();

        // Deselected write must not land; bus released throughout.
        cyc(0, 0, 1, 0, AW'(3), 32'hFFFFFFFF, 1);
        cyc(0, 0, 0, 1, AW'(3), '0, 0);
        cyc(0, 0, 1, 1, AW'(3), '0, 0);
        rd(AW'(3));
        rd(AW'(3));

        // Illegal we=1/oe=1: no write, no drive, rd_q held.
        cyc(0, 1, 1, 1, AW'(4), '0, 0);
        cyc(0, 1, 1, 1, AW'(4), 32'h0BADF00D, 1);
        rd(AW'(4));
        rd(AW'(4));
        idle();

        // Out-of-range: writes ignored, reads capture 0 even after a
        // nonzero word was captured.
        wr(AW'(20), 32'h55AA55AA);
        wr(AW'(31), 32'h77777777);
        rd(AW'(1));
        rd(AW'(20));
        rd(AW'(31));
        rd(AW'(DEPTH - 1));
        idle();
        read_all();

        // Randomized traffic; the bench drives whenever a write is possible
        // and never while a read is active.
        for (int n = 0; n < 400; n++) begin
            rs = ($urandom_range(0, 59) == 0);
            cs = ($urandom_range(0, 3) != 0);
            we = 1'($urandom_range(0, 1));
            oe = 1'($urandom_range(0, 1));
            d  = $urandom();
            if (!rs && cs && !we && oe) drv = 0;
            else if (cs && we)          drv = 1;
            else                        drv = 1'($urandom_range(0, 1));
            cyc(rs, cs, we, oe, AW'($urandom_range(0, 31)), d, drv);
        end
        idle();
        read_all();

        // Fill, then reset during a write to 7: everything reads 0.
        for (int i = 0; i < DEPTH; i++) wr(AW'(i), 32'hA5A5A5A5);
        cyc(1, 1, 1, 0, AW'(7), 32'hA5A5A5A5, 1);
        idle();
        read_all();
        rd(AW'(7));
        rd(AW'(7));
        idle();

        repeat (2) @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Hard stop in case anything stalls.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
